n_serial_adder: RTL and testbench

// Bit-serial N-bit adder: computes sum = a + b + cin one bit per clock, LSB first,

---
 rtl/n_serial_adder.sv | 152 +++++++++++++++
 tb/tb_n_serial_adder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/n_serial_adder.sv
// ---------------------------------------------------------------------------
// n_serial_adder
//
// Bit-serial N-bit adder. Computes {cout, sum} = a + b + cin one bit per
// clock, LSB first, using a single full-adder cell and a carry flop. This is
// intended for area-constrained datapaths that can tolerate N cycles of
// latency.
//
// A start request is only accepted while idle. The operands are captured on
// that edge. The next N edges each resolve one result bit. The cycle after
// the last bit-step raises done for exactly one cycle. The result then stays
// on sum/cout until the next accepted start.
//
// Parameters
//   N      operand/result width in bits (N >= 1)
//
// Ports
//   clk    in   1  single clock, rising-edge
//   rst_n  in   1  synchronous active-low reset, priority over all inputs
//   start  in   1  operation request, only looked at while idle
//   a      in   N  operand A, captured on an accepted start
//   b      in   N  operand B, captured on an accepted start
//   cin    in   1  carry-in, captured on an accepted start
//   busy   out  1  high while an operation is running or finishing
//   done   out  1  one-cycle pulse: sum/cout hold the finished result
//   sum    out  N  registered result bits (intermediate values during RUN)
//   cout   out  1  registered carry-out of the MSB
// ---------------------------------------------------------------------------
module n_serial_adder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  // A one-bit counter is still needed for N=1. $clog2(1) would give zero.
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Counter value during the final (Nth) bit-step.
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  aSh_q,   aSh_d;
  logic [N-1:0]  bSh_q,   bSh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  sum_q,   sum_d;
  logic          cout_q,  cout_d;

  // The single full-adder cell. It always looks at the current LSBs of the
  // operand shifters and the carry flop.
  logic bitSum;
  logic bitCarry;

  always_comb begin
    bitSum   = aSh_q[0] ^ bSh_q[0] ^ carry_q;
    bitCarry = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
  end

  // Next-state logic.
  // In IDLE, an accepted start loads the operand shifters and the carry.
  // sum/cout keep showing the previous result here, because every one of
  // the old result bits is shifted out during RUN anyway.
  // In RUN, each step drops the resolved bit into the sum MSB and shifts
  // everything right. After N steps the LSB has therefore reached bit 0.
  // cout is only written on the final step, where the carry flop's next
  // value is the true carry-out of the MSB.
  always_comb begin
    state_d = state_q;
    aSh_d   = aSh_q;
    bSh_d   = bSh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          aSh_d   = a;
          bSh_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        aSh_d        = aSh_q >> 1;
        bSh_d        = bSh_q >> 1;
        carry_d      = bitCarry;
        sum_d        = sum_q >> 1;
        sum_d[N-1]   = bitSum;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          cout_d  = bitCarry;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  // Reset is synchronous and overrides everything else, including a
  // pending start. An operation that is in flight is aborted without a done
  // pulse, and the visible result is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSh_q   <= aSh_d;
      bSh_q   <= bSh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_n_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_n_serial_adder
//
// Drives three adders side by side, at widths 1, 4 and 16. A reference
// model tracks each one as "operation started k cycles ago" and computes
// the expected result with plain a + b + cin arithmetic. The N=4 instance
// also gets directed operations with literal expected results.
// ---------------------------------------------------------------------------
module tb_n_serial_adder;

  localparam int W [3] = '{1, 4, 16};

  logic clk = 1'b0;
  logic rst_n;

  logic [2:0]       startV;
  logic [2:0][15:0] aV;
  logic [2:0][15:0] bV;
  logic [2:0]       cinV;

  logic [2:0]       busyV;
  logic [2:0]       doneV;
  logic [2:0][15:0] sumW;
  logic [2:0]       coutV;

  logic        busy1, done1, cout1;
  logic [0:0]  sum1;
  logic        busy4, done4, cout4;
  logic [3:0]  sum4;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  // Clock generation.
  always #5 clk = ~clk;

  n_serial_adder #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .a(aV[0][0:0]), .b(bV[0][0:0]),
    .cin(cinV[0]), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  n_serial_adder #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .a(aV[1][3:0]), .b(bV[1][3:0]),
    .cin(cinV[1]), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  n_serial_adder #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]), .a(aV[2]), .b(bV[2]),
    .cin(cinV[2]), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  assign busyV = {busy16, busy4, busy1};
  assign doneV = {done16, done4, done1};
  assign coutV = {cout16, cout4, cout1};
  assign sumW  = {sum16, 16'(sum4), 16'(sum1)};

  function automatic logic [15:0] maskOf(input int w);
    if (w >= 16) return 16'hFFFF;
    return 16'((32'd1 << w) - 32'd1);
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (N=%0d) at %0t: got %0h, expected %0h",
               name, W[inst], $time, actual, expected);
    end
  endtask

  // Reference model.
  // Each adder is either idle or "since" edges past its accepted start.
  // It is busy for since = 0..N, and done exactly at since = N. At done,
  // the result becomes the held value that idle cycles must show.
  bit          active  [3] = '{default: 1'b0};
  int          since   [3] = '{default: 0};
  logic [16:0] res     [3] = '{default: 17'd0};
  logic [15:0] heldSum [3] = '{default: 16'd0};
  logic        heldCout[3] = '{default: 1'b0};
  int          opsDone [3] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        active[i]   = 1'b0;
        heldSum[i]  = 16'd0;
        heldCout[i] = 1'b0;
      end else begin
        bit wasActive;
        wasActive = active[i];
        if (active[i]) begin
          since[i]++;
          if (since[i] == W[i]) begin
            heldSum[i]  = res[i][15:0] & maskOf(W[i]);
            heldCout[i] = res[i][W[i]];
            opsDone[i]++;
          end
          if (since[i] > W[i]) active[i] = 1'b0;
        end
        if (!wasActive && startV[i]) begin
          active[i] = 1'b1;
          since[i]  = 0;
          res[i]    = 17'(aV[i] & maskOf(W[i])) + 17'(bV[i] & maskOf(W[i])) + 17'(cinV[i]);
        end
      end
    end
  end

  // Compare process.
  // One tick after every edge, it checks busy/done for each adder. It also
  // checks sum/cout whenever they are meaningful: on done, or while idle
  // and holding the last result.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      logic expDone;
      expDone = active[i] && (since[i] == W[i]);
      checkOutput("busy", i, 16'(busyV[i]), 16'(active[i]));
      checkOutput("done", i, 16'(doneV[i]), 16'(expDone));
      if (!active[i] || expDone) begin
        checkOutput("sum", i, sumW[i], heldSum[i]);
        checkOutput("cout", i, 16'(coutV[i]), 16'(heldCout[i]));
      end
    end
  end

  // Directed operation on the N=4 adder, with literal expectations.
  // The stimulus and the sampling both happen 3 time units after each edge.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                               input bit holdStart, input logic [3:0] expSum,
                               input logic expCout);
    int busyCycles = 0;
    int waitCycles = 0;
    bit seen = 1'b0;
    @(posedge clk); #3;
    startV[1] = 1'b1;
    aV[1] = 16'(av); bV[1] = 16'(bv); cinV[1] = cv;
    @(posedge clk); #3;
    if (holdStart) begin
      aV[1] = 16'hF; bV[1] = 16'hF; cinV[1] = 1'b1;
    end else begin
      startV[1] = 1'b0;
    end
    while (!seen && waitCycles < 20) begin
      if (busyV[1]) busyCycles++;
      if (doneV[1]) seen = 1'b1;
      else begin
        @(posedge clk); #3;
        waitCycles++;
      end
    end
    checkOutput("lit_done_seen", 1, 16'(seen), 16'd1);
    checkOutput("lit_done_latency", 1, 16'(waitCycles), 16'd4);
    checkOutput("lit_busy_cycles", 1, 16'(busyCycles), 16'd5);
    checkOutput("lit_sum", 1, 16'(sum4), 16'(expSum));
    checkOutput("lit_cout", 1, 16'(cout4), 16'(expCout));
    @(posedge clk); #3;
    checkOutput("lit_done_pulse", 1, 16'(done4), 16'd0);
    if (!holdStart) checkOutput("lit_busy_low", 1, 16'(busy4), 16'd0);
    startV[1] = 1'b0;
    repeat (8) @(posedge clk);
    #3;
  endtask

  // Abort an operation at its second RUN cycle. The outputs must clear,
  // no done pulse may appear, and the next operation must still be correct.
  task automatic applyResetMidRun();
    int doneSeen = 0;
    @(posedge clk); #3;
    startV[1] = 1'b1; aV[1] = 16'h9; bV[1] = 16'h3; cinV[1] = 1'b1;
    @(posedge clk); #3;
    startV[1] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    @(posedge clk); #3;
    checkOutput("rst_busy", 1, 16'(busy4), 16'd0);
    checkOutput("rst_sum", 1, 16'(sum4), 16'd0);
    checkOutput("rst_cout", 1, 16'(cout4), 16'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #3;
      if (done4) doneSeen++;
    end
    checkOutput("rst_no_done", 1, 16'(doneSeen), 16'd0);
    applyStimulus(4'h6, 4'h7, 1'b0, 1'b0, 4'hD, 1'b0);
  endtask

  initial begin
    int cycles = 0;
    rst_n  = 1'b0;
    startV = '0;
    aV     = '0;
    bV     = '0;
    cinV   = '0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_busy", 1, 16'(busy4), 16'd0);
    checkOutput("reset_done", 1, 16'(done4), 16'd0);
    checkOutput("reset_sum", 2, sum16, 16'd0);
    checkOutput("reset_cout", 2, 16'(cout16), 16'd0);
    rst_n = 1'b1;

    $display("[TB] directed operations on N=4");
    applyStimulus(4'h5, 4'h2, 1'b0, 1'b0, 4'h7, 1'b0);
    applyStimulus(4'hA, 4'hA, 1'b0, 1'b0, 4'h4, 1'b1);
    applyStimulus(4'h7, 4'h2, 1'b1, 1'b0, 4'hA, 1'b0);
    applyStimulus(4'h0, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0);
    applyStimulus(4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1);
    applyStimulus(4'h3, 4'h4, 1'b0, 1'b1, 4'h7, 1'b0);
    applyResetMidRun();

    $display("[TB] randomised operations at N=1, 4, 16");
    while ((opsDone[0] < 1000 || opsDone[1] < 1000 || opsDone[2] < 1000) && cycles < 40000) begin
      @(posedge clk); #3;
      for (int i = 0; i < 3; i++) begin
        startV[i] = ($urandom_range(0, 3) != 0);
        aV[i]     = 16'($urandom);
        bV[i]     = 16'($urandom);
        cinV[i]   = 1'($urandom);
      end
      cycles++;
    end
    startV = '0;
    checkOutput("random_ops_budget", 2, 16'(cycles < 40000), 16'd1);
    repeat (20) @(posedge clk);
    #3;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
